keypad_debouncer: RTL and testbench
===================================

Name: keypad_debouncer

Overview:
Front-end for the vending machine's item keypad. It synchronizes and debounces the raw digit buttons, encodes a single clean press into a 4-bit digit, and emits a one-cycle KEY_PRESS strobe with ITEM_CODE. It sits directly upstream of vending_machine and drives its KEY_PRESS and ITEM_CODE inputs. Multi-key presses, bounces and glitches are rejected before they reach the transaction FSM.

Parameters:
NUM_KEYS, 10, number of raw buttons; bit i of KEY_RAW is digit i; legal range 2..16.
DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a press or a release; legal range 2..15.
CNT_W, 4, debounce counter width; must hold DEBOUNCE_CYCLES.

Ports:
CLK  in  1  system clock, rising edge.
RESET  in  1  asynchronous, active-high reset.
KEY_RAW  in  NUM_KEYS  raw, asynchronous, bouncing button levels; 1 means pressed.
ENABLE  in  1  accept presses; when low, completed presses are discarded.
KEY_PRESS  out  1  registered one-cycle strobe for an accepted single-key press.
ITEM_CODE  out  4  binary index of the last accepted key; holds until the next accepted press.
MULTI_KEY  out  1  registered one-cycle strobe when a debounced press has more than one key set.
BUSY  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values (asynchronous, immediate): KEY_PRESS=0, ITEM_CODE=0, MULTI_KEY=0, BUSY=0, synchronizer flops=0, counter=0, sampled pattern=0, state=IDLE.
- Synchronizer: 2-flop synchronizer on every KEY_RAW bit. The FSM sees only the synchronized vector sync.
- FSM states: IDLE, PRESS_DB, HELD, RELEASE_DB.
- IDLE, sync!=0: capture pattern=sync, cnt=1, go to PRESS_DB.
- PRESS_DB, sync==pattern: cnt++.
- PRESS_DB, sync==0: go to IDLE. This is a glitch; no output.
- PRESS_DB, sync!=pattern and sync!=0: recapture pattern=sync, cnt=1. This is a bounce.
- PRESS_DB, cnt==DEBOUNCE_CYCLES on a stable sample (press accepted):
  - popcount(pattern)==1 and ENABLE=1: KEY_PRESS=1 next cycle; ITEM_CODE=index of the set bit, updated on the same edge.
  - popcount(pattern)==1 and ENABLE=0: discard silently.
  - popcount(pattern)>1: MULTI_KEY=1 next cycle; ITEM_CODE unchanged; no KEY_PRESS, regardless of ENABLE.
  - All cases then go to HELD.
- HELD, sync==0: cnt=1, go to RELEASE_DB.
- HELD, any nonzero sync (including a changed key set): stay in HELD. No second press is accepted without a full release.
- RELEASE_DB, sync==0: cnt++. At cnt==DEBOUNCE_CYCLES go to IDLE.
- RELEASE_DB, sync!=0: go to HELD.
- Latency: the new raw level is sampled at edge 1, seen by the FSM at edge 3, and KEY_PRESS is high after edge DEBOUNCE_CYCLES+3. With defaults, KEY_PRESS is high for the cycle after edge 7.
- Strobes: KEY_PRESS and MULTI_KEY are exactly one cycle and never both high.
- ENABLE: sampled only at press acceptance. Raising ENABLE while a key is held does not create a press.
- BUSY = (state != IDLE); combinational from the state register.
- Reset mid-operation returns the block to IDLE. A key still held after reset deasserts is treated as a new press and is debounced from scratch.
- Keys with index >= NUM_KEYS do not exist. ITEM_CODE is zero-extended to 4 bits.

Decomposition:
- Shared package (vending_pkg): FSM state encoding (2-bit localparams IDLE, PRESS_DB, HELD, RELEASE_DB), default DEBOUNCE_CYCLES, and ITEM_CODE width 4. This width is shared with vending_machine.
- One sub-module, key_synchronizer: parameterized-width 2-flop synchronizer with async active-high reset.
- Popcount and the one-hot-to-binary encoder are coded inline as functions in keypad_debouncer.

Test Plan:
1. Clean press: ENABLE=1, KEY_RAW=10'b0000000010 held 12 cycles, then released -> single KEY_PRESS pulse after edge 7, ITEM_CODE=1 and held after release, BUSY low again 2+4+1 cycles after release.
2. Bounce: key 3 toggles 1,0,1,0,1 on consecutive cycles, then stays stable -> exactly one KEY_PRESS, ITEM_CODE=3, first pulse DEBOUNCE_CYCLES+3 edges after the last toggle.
3. Glitch: key 5 high for 2 cycles only -> no KEY_PRESS, no MULTI_KEY, ITEM_CODE unchanged from the prior value (1).
4. Multi-key: keys 2 and 4 asserted together and stable -> MULTI_KEY one-cycle pulse, KEY_PRESS=0, ITEM_CODE unchanged.
5. Enable gating: ENABLE=0, press key 7 stably; raise ENABLE while held -> no pulse. Release fully, re-press key 7 -> KEY_PRESS, ITEM_CODE=7.
6. Reset mid-debounce: assert RESET during PRESS_DB -> all outputs 0 immediately. With the key still held after reset release -> KEY_PRESS after DEBOUNCE_CYCLES+3 edges, ITEM_CODE set to that key.

Source files
------------

// File: rtl/vending_pkg.sv
// Shared definitions for the vending machine front-end and transaction FSM.
package vending_pkg;
  localparam int ITEM_W           = 4;
  localparam int DEBOUNCE_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } kb_state_t;
endpackage

// File: rtl/key_synchronizer.sv
// Two-flop synchronizer for a vector of asynchronous button levels.
module key_synchronizer #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_async,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d_async;
      q    <= meta;
    end
  end
endmodule

// File: rtl/keypad_debouncer.sv
// Debounces the item keypad and emits a one-cycle strobe per clean single-key press.
module keypad_debouncer
  import vending_pkg::*;
#(
  parameter int NUM_KEYS        = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W           = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [NUM_KEYS-1:0] KEY_RAW,
  input  logic                ENABLE,
  output logic                KEY_PRESS,
  output logic [ITEM_W-1:0]   ITEM_CODE,
  output logic                MULTI_KEY,
  output logic                BUSY
);
  kb_state_t           state, state_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [NUM_KEYS-1:0] sync, pattern, pattern_n;
  logic                accept, single, key_press_n, multi_n;

  function automatic logic [4:0] popcount(input logic [NUM_KEYS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_KEYS; i++) popcount = popcount + 5'(v[i]);
  endfunction

  function automatic logic [ITEM_W-1:0] encode(input logic [NUM_KEYS-1:0] v);
    encode = '0;
    for (int i = 0; i < NUM_KEYS; i++) if (v[i]) encode = ITEM_W'(i);
  endfunction

  key_synchronizer #(.W(NUM_KEYS)) u_sync (
    .clk    (CLK),
    .rst    (RESET),
    .d_async(KEY_RAW),
    .q      (sync)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state   <= IDLE;
      cnt     <= '0;
      pattern <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      pattern <= pattern_n;
    end
  end

  // Acceptance happens on the stable sample that finds the counter already full.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    pattern_n = pattern;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (sync != '0) begin
          pattern_n = sync;
          cnt_n     = CNT_W'(1);
          state_n   = PRESS_DB;
        end
      end
      PRESS_DB: begin
        if (sync == '0) begin
          state_n = IDLE;
        end else if (sync != pattern) begin
          pattern_n = sync;
          cnt_n     = CNT_W'(1);
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          accept  = 1'b1;
          state_n = HELD;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      HELD: begin
        if (sync == '0) begin
          cnt_n   = CNT_W'(1);
          state_n = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (sync != '0) begin
          state_n = HELD;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign single      = (popcount(pattern) == 5'd1);
  assign key_press_n = accept & single & ENABLE;
  assign multi_n     = accept & (popcount(pattern) > 5'd1);
  assign BUSY        = (state != IDLE);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      KEY_PRESS <= 1'b0;
      MULTI_KEY <= 1'b0;
      ITEM_CODE <= '0;
    end else begin
      KEY_PRESS <= key_press_n;
      MULTI_KEY <= multi_n;
      if (key_press_n) ITEM_CODE <= encode(pattern);
    end
  end
endmodule

// File: tb/tb_keypad_debouncer.sv
// Self-checking bench: directed scenarios plus random key activity against a run-length reference model.
module tb_keypad_debouncer;
  localparam int NK = 10;
  localparam int DB = 4;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          ENABLE = 1'b0;
  logic [NK-1:0] KEY_RAW = '0;
  logic          KEY_PRESS, MULTI_KEY, BUSY;
  logic [3:0]    ITEM_CODE;

  int checks = 0;
  int errors = 0;

  keypad_debouncer #(.NUM_KEYS(NK), .DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .KEY_RAW  (KEY_RAW),
    .ENABLE   (ENABLE),
    .KEY_PRESS(KEY_PRESS),
    .ITEM_CODE(ITEM_CODE),
    .MULTI_KEY(MULTI_KEY),
    .BUSY     (BUSY)
  );

  always #5 CLK = ~CLK;

  // Reference: a press is accepted when the same nonzero synchronized value has
  // been seen DB+1 times in a row; a release when zero has been seen DB+1 times.
  logic [NK-1:0] m_s1, m_s2, m_last;
  int            m_run, m_zrun;
  logic          m_pressed, m_kp, m_mk, m_busy;
  logic [3:0]    m_item;

  always @(posedge CLK or posedge RESET) begin : model
    logic [NK-1:0] seen;
    int            run, zrun;
    logic          pressed, kp, mk;
    logic [3:0]    item;
    if (RESET) begin
      m_s1 <= '0; m_s2 <= '0; m_last <= '0;
      m_run <= 0; m_zrun <= 0; m_pressed <= 1'b0;
      m_kp <= 1'b0; m_mk <= 1'b0; m_item <= '0;
    end else begin
      seen = m_s2; run = m_run; zrun = m_zrun; pressed = m_pressed;
      kp = 1'b0; mk = 1'b0; item = m_item;
      if (!pressed) begin
        if (seen == '0) run = 0;
        else if (run > 0 && seen == m_last) run = run + 1;
        else run = 1;
        if (run == DB + 1) begin
          pressed = 1'b1;
          zrun    = 0;
          if ($countones(seen) > 1) mk = 1'b1;
          else if (ENABLE) begin
            kp = 1'b1;
            for (int i = 0; i < NK; i++) if (seen[i]) item = i[3:0];
          end
        end
      end else begin
        if (seen == '0) zrun = zrun + 1;
        else zrun = 0;
        if (zrun == DB + 1) begin
          pressed = 1'b0;
          run     = 0;
        end
      end
      m_last <= seen; m_run <= run; m_zrun <= zrun; m_pressed <= pressed;
      m_kp <= kp; m_mk <= mk; m_item <= item;
      m_s2 <= m_s1; m_s1 <= KEY_RAW;
    end
  end

  assign m_busy = m_pressed | (m_run > 0);

  logic [6:0] obs, expv;
  assign obs  = {KEY_PRESS, MULTI_KEY, BUSY, ITEM_CODE};
  assign expv = {m_kp, m_mk, m_busy, m_item};

  task automatic test_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL reset_state: got %b want %b", obs, 7'b0);
    end
    RESET = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== 7'b0) begin
        errors++; $display("FAIL reset_idle cycle %0d: got %b want %b", e, obs, 7'b0);
      end
    end
  endtask

  task automatic test_clean_press();
    int first, pulses;
    first = -1; pulses = 0;
    ENABLE = 1'b1; KEY_RAW = '0; KEY_RAW[1] = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL clean_press cycle %0d: got %b want %b", e, obs, expv);
      end
      if (KEY_PRESS === 1'b1) begin pulses++; if (first < 0) first = e; end
      if (e == 18 || e == 19) begin
        checks++;
        if (BUSY !== (e == 18)) begin
          errors++; $display("FAIL clean_busy_release cycle %0d: got %b want %b", e, BUSY, e == 18);
        end
      end
      if (e == 12) KEY_RAW = '0;
    end
    checks++;
    if (first != DB + 3 || pulses != 1) begin
      errors++; $display("FAIL clean_latency: got first=%0d pulses=%0d want first=%0d pulses=1", first, pulses, DB + 3);
    end
    checks++;
    if (ITEM_CODE !== 4'd1) begin
      errors++; $display("FAIL clean_item: got %0d want 1", ITEM_CODE);
    end
  endtask

  task automatic test_glitch();
    int strobes;
    strobes = 0;
    KEY_RAW = '0; KEY_RAW[5] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL glitch cycle %0d: got %b want %b", e, obs, expv);
      end
      if (KEY_PRESS === 1'b1 || MULTI_KEY === 1'b1) strobes++;
      if (e == 2) KEY_RAW = '0;
    end
    checks++;
    if (strobes != 0 || ITEM_CODE !== 4'd1) begin
      errors++; $display("FAIL glitch_outputs: got strobes=%0d item=%0d want strobes=0 item=1", strobes, ITEM_CODE);
    end
  endtask

  task automatic test_bounce();
    int first, pulses;
    logic [4:0] toggles;
    first = -1; pulses = 0; toggles = 5'b10101;
    for (int e = 1; e <= 28; e++) begin
      if (e <= 5) begin KEY_RAW = '0; KEY_RAW[3] = toggles[e-1]; end
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL bounce cycle %0d: got %b want %b", e, obs, expv);
      end
      if (KEY_PRESS === 1'b1) begin pulses++; if (first < 0) first = e; end
      if (e == 16) KEY_RAW = '0;
    end
    checks++;
    if (first != 5 + DB + 2 || pulses != 1 || ITEM_CODE !== 4'd3) begin
      errors++; $display("FAIL bounce_result: got first=%0d pulses=%0d item=%0d want first=%0d pulses=1 item=3",
                         first, pulses, ITEM_CODE, 5 + DB + 2);
    end
  endtask

  task automatic test_multi_key();
    int mk_first, mk_pulses, kp_pulses;
    mk_first = -1; mk_pulses = 0; kp_pulses = 0;
    KEY_RAW = '0; KEY_RAW[2] = 1'b1; KEY_RAW[4] = 1'b1;
    for (int e = 1; e <= 22; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL multi_key cycle %0d: got %b want %b", e, obs, expv);
      end
      if (MULTI_KEY === 1'b1) begin mk_pulses++; if (mk_first < 0) mk_first = e; end
      if (KEY_PRESS === 1'b1) kp_pulses++;
      if (e == 10) KEY_RAW = '0;
    end
    checks++;
    if (mk_first != DB + 3 || mk_pulses != 1 || kp_pulses != 0 || ITEM_CODE !== 4'd3) begin
      errors++; $display("FAIL multi_key_result: got first=%0d mk=%0d kp=%0d item=%0d want first=%0d mk=1 kp=0 item=3",
                         mk_first, mk_pulses, kp_pulses, ITEM_CODE, DB + 3);
    end
  endtask

  task automatic test_enable_gating();
    int first, pulses, gated;
    first = -1; pulses = 0; gated = 0;
    ENABLE = 1'b0; KEY_RAW = '0; KEY_RAW[7] = 1'b1;
    for (int e = 1; e <= 24; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL enable_gated cycle %0d: got %b want %b", e, obs, expv);
      end
      if (KEY_PRESS === 1'b1) gated++;
      if (e == 9) ENABLE = 1'b1;
      if (e == 14) KEY_RAW = '0;
    end
    KEY_RAW[7] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL enable_repress cycle %0d: got %b want %b", e, obs, expv);
      end
      if (KEY_PRESS === 1'b1) begin pulses++; if (first < 0) first = e; end
    end
    checks++;
    if (gated != 0 || first != DB + 3 || pulses != 1 || ITEM_CODE !== 4'd7) begin
      errors++; $display("FAIL enable_result: got gated=%0d first=%0d pulses=%0d item=%0d want gated=0 first=%0d pulses=1 item=7",
                         gated, first, pulses, ITEM_CODE, DB + 3);
    end
  endtask

  task automatic test_reset_mid();
    int first, pulses;
    first = -1; pulses = 0;
    KEY_RAW = '0;
    repeat (12) @(negedge CLK);
    KEY_RAW[9] = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL reset_mid_pre cycle %0d: got %b want %b", e, obs, expv);
      end
    end
    #2 RESET = 1'b1;
    #1;
    checks++;
    if (obs !== 7'b0) begin
      errors++; $display("FAIL reset_mid_async: got %b want %b", obs, 7'b0);
    end
    @(negedge CLK);
    RESET = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL reset_mid_post cycle %0d: got %b want %b", e, obs, expv);
      end
      if (KEY_PRESS === 1'b1) begin pulses++; if (first < 0) first = e; end
    end
    checks++;
    if (first != DB + 3 || pulses != 1 || ITEM_CODE !== 4'd9) begin
      errors++; $display("FAIL reset_mid_result: got first=%0d pulses=%0d item=%0d want first=%0d pulses=1 item=9",
                         first, pulses, ITEM_CODE, DB + 3);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      int kind, hold;
      kind = $urandom_range(0, 4);
      hold = $urandom_range(1, 12);
      ENABLE = ($urandom_range(0, 3) != 0);
      KEY_RAW = '0;
      if (kind == 1 || kind == 2) KEY_RAW[$urandom_range(0, NK - 1)] = 1'b1;
      else if (kind == 3) KEY_RAW = NK'($urandom_range(0, (1 << NK) - 1));
      else if (kind == 4) KEY_RAW = m_s1;
      for (int h = 0; h < hold; h++) begin
        @(negedge CLK);
        checks++;
        if (obs !== expv) begin
          errors++; $display("FAIL random step %0d.%0d: got %b want %b", n, h, obs, expv);
        end
      end
    end
    KEY_RAW = '0;
    for (int e = 1; e <= 12; e++) begin
      @(negedge CLK);
      checks++;
      if (obs !== expv) begin
        errors++; $display("FAIL random_drain cycle %0d: got %b want %b", e, obs, expv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_bounce();
    test_multi_key();
    test_enable_gating();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
